// File: rtl/main_ctrl_fsm.sv
// Multi-cycle main control FSM for the SCPU core: fetch/decode/exec/mem/wb sequencing and aluop.
// Optional bus-timeout trap is compiled in with `define MAINCTRL_BUS_TIMEOUT_EN.
module main_ctrl_fsm #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] instr,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        branch_taken,
   output logic        imem_req,
   output logic        ir_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic [2:0]  aluop,
   output logic        alu_src_a,
   output logic        alu_src_b,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic        instr_done,
   output logic        trap
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   state_t     state_q, state_d;
   logic [6:0] op_q;
   logic [2:0] aluop_dec;
   logic       timeout_hit;
   logic       unused_instr;

   assign unused_instr = ^instr[31:7];

   function automatic logic [2:0] decode_aluop(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE: decode_aluop = 3'b000;
         OP_BRANCH:         decode_aluop = 3'b001;
         OP_R:              decode_aluop = 3'b010;
         OP_I:              decode_aluop = 3'b011;
         OP_LUI:            decode_aluop = 3'b100;
         OP_AUIPC:          decode_aluop = 3'b101;
         OP_JALR:           decode_aluop = 3'b110;
         OP_JAL:            decode_aluop = 3'b111;
         default:           decode_aluop = 3'b000;
      endcase
   endfunction

   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_BRANCH, OP_R, OP_I,
         OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: is_legal = 1'b1;
         default:                           is_legal = 1'b0;
      endcase
   endfunction

   assign aluop_dec = decode_aluop(op_q);

   // Opcode is a datapath register: captured with the IR, not reset.
   always_ff @(posedge clk) begin
      if (ir_we) op_q <= instr[6:0];
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

`ifdef MAINCTRL_BUS_TIMEOUT_EN
   logic [7:0] wait_cnt_q;
   logic       waiting;

   assign waiting     = ((state_q == S_FETCH) && !imem_ready) ||
                        ((state_q == S_MEM)   && !dmem_ready);
   // The current wait cycle is the TIMEOUT_CYCLES-th one; ready in this cycle still wins.
   assign timeout_hit = waiting && (wait_cnt_q == 8'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst || (state_d != state_q)) wait_cnt_q <= 8'd0;
      else if (waiting)                wait_cnt_q <= wait_cnt_q + 8'd1;
   end
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      imem_req   = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = 2'b00;
      aluop      = 3'b000;
      alu_src_a  = 1'b0;
      alu_src_b  = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      reg_we     = 1'b0;
      wb_sel     = 2'b00;
      instr_done = 1'b0;
      trap       = 1'b0;
      // Every output is held low while rst is asserted, whatever the current state.
      if (!rst) begin
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we   = 1'b1;
                  state_d = S_DECODE;
               end else if (timeout_hit) begin
                  state_d = S_TRAP;
               end
            end
            S_DECODE: begin
               aluop   = aluop_dec;
               state_d = is_legal(op_q) ? S_EXEC : S_TRAP;
            end
            S_EXEC: begin
               aluop     = aluop_dec;
               alu_src_a = (op_q == OP_AUIPC) || (op_q == OP_JAL) || (op_q == OP_BRANCH);
               alu_src_b = !((op_q == OP_R) || (op_q == OP_BRANCH));
               if (op_q == OP_BRANCH) begin
                  pc_we      = 1'b1;
                  instr_done = 1'b1;
                  pc_sel     = branch_taken ? 2'b01 : 2'b00;
                  state_d    = S_FETCH;
               end else if ((op_q == OP_LOAD) || (op_q == OP_STORE)) begin
                  state_d = S_MEM;
               end else begin
                  state_d = S_WB;
               end
            end
            S_MEM: begin
               aluop    = aluop_dec;
               dmem_req = 1'b1;
               dmem_we  = (op_q == OP_STORE);
               if (dmem_ready) begin
                  if (op_q == OP_STORE) begin
                     pc_we      = 1'b1;
                     instr_done = 1'b1;
                     state_d    = S_FETCH;
                  end else begin
                     state_d = S_WB;
                  end
               end else if (timeout_hit) begin
                  state_d = S_TRAP;
               end
            end
            S_WB: begin
               aluop      = aluop_dec;
               reg_we     = 1'b1;
               pc_we      = 1'b1;
               instr_done = 1'b1;
               if (op_q == OP_LOAD) begin
                  wb_sel = 2'b01;
               end else if (op_q == OP_JAL) begin
                  wb_sel = 2'b10;
                  pc_sel = 2'b01;
               end else if (op_q == OP_JALR) begin
                  wb_sel = 2'b10;
                  pc_sel = 2'b10;
               end
               state_d = S_FETCH;
            end
            S_TRAP: begin
               trap = 1'b1;
            end
            default: begin
               state_d = S_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed-vector bench for main_ctrl_fsm; all outputs are packed into one word and compared per cycle.
// Field order: imem_req ir_we pc_we pc_sel[2] aluop[3] src_a src_b dmem_req dmem_we reg_we wb_sel[2] done trap.
module tb_main_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] instr = 32'd0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic        imem_req, ir_we, pc_we, alu_src_a, alu_src_b;
   logic        dmem_req, dmem_we, reg_we, instr_done, trap;
   logic [1:0]  pc_sel, wb_sel;
   logic [2:0]  aluop;
   logic [16:0] obs;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   main_ctrl_fsm #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .instr(instr), .imem_ready(imem_ready),
      .dmem_ready(dmem_ready), .branch_taken(branch_taken),
      .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
      .aluop(aluop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we),
      .wb_sel(wb_sel), .instr_done(instr_done), .trap(trap)
   );

   assign obs = {imem_req, ir_we, pc_we, pc_sel, aluop, alu_src_a, alu_src_b,
                 dmem_req, dmem_we, reg_we, wb_sel, instr_done, trap};

   localparam logic [16:0] ZERO   = 17'b0_0_0_00_000_0_0_0_0_0_00_0_0;
   localparam logic [16:0] F_RDY  = 17'b1_1_0_00_000_0_0_0_0_0_00_0_0;
   localparam logic [16:0] F_WAIT = 17'b1_0_0_00_000_0_0_0_0_0_00_0_0;
   localparam logic [16:0] TRAPV  = 17'b0_0_0_00_000_0_0_0_0_0_00_0_1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", tag, act[16:0], exp[16:0]);
      end
   endtask

   // One clock: drive inputs, compare outputs at the falling edge, advance past the rising edge.
   task automatic cyc(input string tag, input logic ir, input logic dr, input logic bt,
                      input logic [16:0] e);
      imem_ready   = ir;
      dmem_ready   = dr;
      branch_taken = bt;
      @(negedge clk);
      chk(tag, {15'd0, obs}, {15'd0, e});
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      cyc(tag, 1'b1, 1'b1, 1'b1, ZERO);
      rst = 1'b0;
   endtask

   initial begin
      do_reset("reset");

      // ADD: four cycles, R-type, ready inputs toggled outside their states
      instr = 32'h002081B3;
      cyc("add_fetch",  1, 0, 0, F_RDY);
      cyc("add_decode", 1, 1, 0, 17'b0_0_0_00_010_0_0_0_0_0_00_0_0);
      cyc("add_exec",   1, 1, 1, 17'b0_0_0_00_010_0_0_0_0_0_00_0_0);
      cyc("add_wb",     0, 1, 0, 17'b0_0_1_00_010_0_0_0_0_1_00_1_0);
      cyc("add_next",   0, 0, 0, F_WAIT);

      // LW with three dmem wait cycles
      instr = 32'h0000A103;
      cyc("lw_fetch",  1, 0, 0, F_RDY);
      cyc("lw_decode", 0, 1, 0, ZERO);
      cyc("lw_exec",   0, 1, 0, 17'b0_0_0_00_000_0_1_0_0_0_00_0_0);
      cyc("lw_mem_w1", 1, 0, 0, 17'b0_0_0_00_000_0_0_1_0_0_00_0_0);
      cyc("lw_mem_w2", 0, 0, 0, 17'b0_0_0_00_000_0_0_1_0_0_00_0_0);
      cyc("lw_mem_w3", 0, 0, 0, 17'b0_0_0_00_000_0_0_1_0_0_00_0_0);
      cyc("lw_mem_rd", 0, 1, 0, 17'b0_0_0_00_000_0_0_1_0_0_00_0_0);
      cyc("lw_wb",     0, 0, 0, 17'b0_0_1_00_000_0_0_0_0_1_01_1_0);

      // BEQ taken, then not taken
      instr = 32'h00208463;
      cyc("beq1_fetch",  1, 0, 1, F_RDY);
      cyc("beq1_decode", 0, 0, 1, 17'b0_0_0_00_001_0_0_0_0_0_00_0_0);
      cyc("beq1_exec",   0, 0, 1, 17'b0_0_1_01_001_1_0_0_0_0_00_1_0);
      cyc("beq2_fetch",  1, 0, 1, F_RDY);
      cyc("beq2_decode", 0, 0, 1, 17'b0_0_0_00_001_0_0_0_0_0_00_0_0);
      cyc("beq2_exec",   0, 0, 0, 17'b0_0_1_00_001_1_0_0_0_0_00_1_0);

      // SW with one dmem wait cycle
      instr = 32'h0020A023;
      cyc("sw_fetch",  1, 0, 0, F_RDY);
      cyc("sw_decode", 0, 0, 0, ZERO);
      cyc("sw_exec",   0, 0, 0, 17'b0_0_0_00_000_0_1_0_0_0_00_0_0);
      cyc("sw_mem_w",  0, 0, 0, 17'b0_0_0_00_000_0_0_1_1_0_00_0_0);
      cyc("sw_mem_rd", 0, 1, 0, 17'b0_0_1_00_000_0_0_1_1_0_00_1_0);

      // JALR
      instr = 32'h000080E7;
      cyc("jalr_fetch",  1, 0, 0, F_RDY);
      cyc("jalr_decode", 0, 0, 0, 17'b0_0_0_00_110_0_0_0_0_0_00_0_0);
      cyc("jalr_exec",   0, 0, 0, 17'b0_0_0_00_110_0_1_0_0_0_00_0_0);
      cyc("jalr_wb",     0, 0, 0, 17'b0_0_1_10_110_0_0_0_0_1_10_1_0);

      // JAL
      instr = 32'h0000006F;
      cyc("jal_fetch",  1, 0, 0, F_RDY);
      cyc("jal_decode", 0, 0, 0, 17'b0_0_0_00_111_0_0_0_0_0_00_0_0);
      cyc("jal_exec",   0, 0, 0, 17'b0_0_0_00_111_1_1_0_0_0_00_0_0);
      cyc("jal_wb",     0, 0, 0, 17'b0_0_1_01_111_0_0_0_0_1_10_1_0);

      // AUIPC then LUI (exec selects only)
      instr = 32'h00000097;
      cyc("auipc_fetch", 1, 0, 0, F_RDY);
      cyc("auipc_dec",   0, 0, 0, 17'b0_0_0_00_101_0_0_0_0_0_00_0_0);
      cyc("auipc_exec",  0, 0, 0, 17'b0_0_0_00_101_1_1_0_0_0_00_0_0);
      cyc("auipc_wb",    0, 0, 0, 17'b0_0_1_00_101_0_0_0_0_1_00_1_0);
      instr = 32'h000000B7;
      cyc("lui_fetch", 1, 0, 0, F_RDY);
      cyc("lui_dec",   0, 0, 0, 17'b0_0_0_00_100_0_0_0_0_0_00_0_0);
      cyc("lui_exec",  0, 0, 0, 17'b0_0_0_00_100_0_1_0_0_0_00_0_0);
      cyc("lui_wb",    0, 0, 0, 17'b0_0_1_00_100_0_0_0_0_1_00_1_0);

      // Reset in EXEC of an ADD abandons it
      instr = 32'h002081B3;
      cyc("abort_fetch",  1, 0, 0, F_RDY);
      cyc("abort_decode", 0, 0, 0, 17'b0_0_0_00_010_0_0_0_0_0_00_0_0);
      do_reset("abort_rst");
      cyc("abort_after",  0, 0, 0, F_WAIT);

      // Illegal opcode traps from cycle 3 and stays there
      instr = 32'h0000000B;
      cyc("ill_fetch",  1, 0, 0, F_RDY);
      cyc("ill_decode", 1, 1, 1, ZERO);
      for (int i = 0; i < 20; i++) cyc($sformatf("ill_trap%0d", i), 1, 1, 1, TRAPV);
      do_reset("ill_rst");
      cyc("ill_after", 0, 0, 0, F_WAIT);

`ifdef MAINCTRL_BUS_TIMEOUT_EN
      do_reset("to_rst");
      for (int i = 0; i < 4; i++) cyc($sformatf("to_wait%0d", i), 0, 0, 0, F_WAIT);
      cyc("to_trap", 0, 0, 0, TRAPV);
      do_reset("to_rst2");
      instr = 32'h002081B3;
      for (int i = 0; i < 3; i++) cyc($sformatf("to_win_wait%0d", i), 0, 0, 0, F_WAIT);
      cyc("to_win_rdy", 1, 0, 0, F_RDY);
      cyc("to_win_dec", 0, 0, 0, 17'b0_0_0_00_010_0_0_0_0_0_00_0_0);
`else
      do_reset("nto_rst");
      for (int i = 0; i < 100; i++) cyc($sformatf("nto_wait%0d", i), 0, 0, 0, F_WAIT);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
